nbit_serial_adder: RTL and testbench

- Multi-cycle, digit-serial N-bit adder. Computes sum = A + B with carry-out, DIGIT bits per clock, LSB digit first.
- Inverse companion to the team's N-bit subtractor. Adding B back to (A - B) recovers A mod 2^N. Used wherever area matters more than latency.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.

---
 rtl/nbit_arith_pkg.sv | 16 +
 rtl/serial_digit_adder.sv | 24 ++
 rtl/nbit_serial_adder.sv | 117 +++++++++++
 tb/tb_nbit_serial_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nbit_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks (add, subtract, compare).
//   serial_state_t : IDLE / RUN / DONE control states
//   digits()       : number of DIGIT-wide steps needed to cover an N-bit operand
package nbit_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } serial_state_t;

  function automatic int unsigned digits(input int unsigned n, input int unsigned digit);
    return n / digit;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit adder slice with carry in/out.
//   a, b : DIGIT-bit operand digits
//   cin  : carry in from the previous digit
//   s    : DIGIT-bit sum digit
//   cout : carry out to the next digit
module serial_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    s     = total[DIGIT-1:0];
    cout  = total[DIGIT];
  end

endmodule

// File: rtl/nbit_serial_adder.sv
// Digit-serial N-bit adder: sum = A + B, DIGIT bits per clock, LSB digit first.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  : operand handshake; A/B sampled on the accept edge
//   A, B                : N-bit unsigned operands
//   out_valid, out_ready: result handshake; sum/carry_out held until released
//   sum, carry_out      : (A + B) mod 2^N and bit N; zero outside DONE
//   busy                : high in RUN or DONE
module nbit_serial_adder
  import nbit_arith_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         busy
);

  localparam int unsigned NDigits = digits(N, DIGIT);
  localparam int unsigned CntW    = $clog2(NDigits) + 1;

  if (DIGIT == 0 || (N % DIGIT) != 0) begin : g_bad_digit
    $error("nbit_serial_adder: N must be a non-zero multiple of DIGIT");
  end

  serial_state_t   state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [DIGIT-1:0] digit;
  logic             digit_cout;
  logic             last_digit;

  serial_digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (a_sh_q[DIGIT-1:0]),
    .b   (b_sh_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (digit),
    .cout(digit_cout)
  );

  assign last_digit = (cnt_q == CntW'(NDigits - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // New digit enters at the MSB end; after NDigits steps the LSB digit sits at bit 0.
        sum_d   = sum_q >> DIGIT;
        sum_d[N-1 -: DIGIT] = digit;
        carry_d = digit_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = (state_q == DONE) ? sum_q : '0;
    carry_out = (state_q == DONE) ? carry_q : 1'b0;
  end

endmodule

// File: tb/tb_nbit_serial_adder.sv
module tb_nbit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DIGIT=1 instance
  logic       iv1, ir1, ov1, or1, c1, busy1;
  logic [7:0] a1, b1, s1;
  // DIGIT=4 and DIGIT=8 instances share stimulus
  logic       iv48, or48;
  logic [7:0] a48, b48;
  logic       ir4, ov4, c4, busy4, ir8, ov8, c8, busy8;
  logic [7:0] s4, s8;

  nbit_serial_adder #(.N(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(c1), .busy(busy1)
  );
  nbit_serial_adder #(.N(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv48), .in_ready(ir4), .A(a48), .B(b48),
    .out_valid(ov4), .out_ready(or48), .sum(s4), .carry_out(c4), .busy(busy4)
  );
  nbit_serial_adder #(.N(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv48), .in_ready(ir8), .A(a48), .B(b48),
    .out_valid(ov8), .out_ready(or48), .sum(s8), .carry_out(c8), .busy(busy8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 9-bit unsigned addition.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Wait for in_ready, accept (a,b) on DIGIT=1 DUT, wait for out_valid.
  // Leaves in_valid as given by keep_valid; the caller performs the release edge.
  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic keep_valid,
                     input logic poke, output int lat);
    int w;
    w = 0;
    while (!ir1 && w < 50) begin tick(); w++; end
    if (!ir1) check("d1 in_ready timeout", 0, 1);
    a1 = a; b1 = b; iv1 = 1'b1;
    tick();
    iv1 = keep_valid;
    lat = 0;
    while (!ov1 && lat < 50) begin
      if (poke) begin
        iv1 = lat[0];
        a1 = 8'hFF; b1 = 8'hFF;
        check("run in_ready low", ir1, 0);
      end
      tick();
      lat++;
    end
    if (poke) iv1 = 1'b0;
    if (!ov1) check("d1 out_valid timeout", 0, 1);
  endtask

  task automatic release1();
    or1 = 1'b1;
    tick();
    check("ov drops after release", ov1, 0);
    check("in_ready after release", ir1, 1);
  endtask

  task automatic op48(input logic [7:0] a, input logic [7:0] b);
    int cy, l4, l8;
    logic [8:0] r4, r8, exp;
    exp = ref_add(a, b);
    check("d4 idle", ir4, 1);
    check("d8 idle", ir8, 1);
    a48 = a; b48 = b; iv48 = 1'b1; or48 = 1'b1;
    tick();
    iv48 = 1'b0;
    cy = 0; l4 = -1; l8 = -1; r4 = '0; r8 = '0;
    while (cy < 20 && (l4 < 0 || l8 < 0)) begin
      if (ov4 && l4 < 0) begin l4 = cy; r4 = {c4, s4}; end
      if (ov8 && l8 < 0) begin l8 = cy; r8 = {c8, s8}; end
      tick();
      cy++;
    end
    check("d4 latency", l4, 2);
    check("d8 latency", l8, 1);
    check("d4 result", r4, exp);
    check("d8 result", r8, exp);
    tick();
  endtask

  initial begin
    int lat;
    logic [8:0] exp;
    logic [7:0] ra, rb, d;

    iv1 = 0; a1 = 0; b1 = 0; or1 = 1;
    iv48 = 0; a48 = 0; b48 = 0; or48 = 1;
    #12;
    check("reset ov", ov1, 0);
    check("reset sum", s1, 0);
    check("reset carry", c1, 0);
    check("reset busy", busy1, 0);
    check("reset in_ready", ir1, 1);
    rst = 1'b0;
    tick();

    // Basic add with latency check
    op1(8'h5A, 8'h33, 1'b0, 1'b0, lat);
    check("5A+33 latency", lat, 8);
    check("5A+33 sum", s1, 8'h8D);
    check("5A+33 carry", c1, 0);
    check("5A+33 busy", busy1, 1);
    release1();

    op1(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    check("FF+01 sum", s1, 8'h00);
    check("FF+01 carry", c1, 1);
    release1();

    op1(8'h80, 8'h80, 1'b0, 1'b0, lat);
    check("80+80 sum", s1, 8'h00);
    check("80+80 carry", c1, 1);
    release1();

    // Backpressure with ignored in_valid pulses
    or1 = 1'b0;
    op1(8'h10, 8'h20, 1'b0, 1'b1, lat);
    check("bp latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      iv1 = i[0]; a1 = 8'hAA; b1 = 8'h55;
      check("bp sum stable", s1, 8'h30);
      check("bp ov held", ov1, 1);
      check("bp in_ready low", ir1, 0);
      tick();
    end
    iv1 = 1'b0;
    check("bp sum before release", s1, 8'h30);
    release1();

    // Reset mid-run
    a1 = 8'h44; b1 = 8'h22; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("rst ov", ov1, 0);
    check("rst sum", s1, 0);
    check("rst busy", busy1, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst in_ready", ir1, 1);
    op1(8'h01, 8'h02, 1'b0, 1'b0, lat);
    check("post-rst sum", s1, 8'h03);
    check("post-rst carry", c1, 0);
    release1();

    // DIGIT=4 / DIGIT=8 instances
    op48(8'h9C, 8'h77);
    for (int i = 0; i < 30; i++) op48(8'($urandom), 8'($urandom));

    // Round trip: (A - B) + B == A, back-to-back with in_valid held high
    or1 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      d  = ra - rb;
      op1(d, rb, 1'b1, 1'b0, lat);
      exp = ref_add(d, rb);
      check("rt sum", s1, ra);
      if (i < 40) begin
        check("rt latency", lat, 8);
        check("rt carry", c1, exp[8]);
      end
      tick();
      // in_valid still high: back in IDLE, no same-cycle re-accept
      check("rt no re-accept", {ov1, busy1, ir1}, 3'b001);
    end
    iv1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
